writeback_stage: RTL and testbench

Final pipeline stage of the RISC-V core. It accepts completed instructions from execute over a valid/ready handshake and waits for load data from the data-memory response channel. It formats load data (byte/half/word, sign/zero extension) and drives the register file write port (write, rd_addr, rd) from registered outputs. It also exports a pending-load hazard indication and a retired-instruction counter.

---
 rtl/writeback_stage.sv | 151 +++++++++++++++
 tb/tb_writeback_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results in 1 cycle and load data 1 cycle after mem_rvalid.
// ex_ready is low while a load waits for memory, so execute stalls until the response arrives.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd_addr,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [1:0]       ex_addr_lo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_write,
  output logic [4:0]       rf_rd_addr,
  output logic [XLEN-1:0]  rf_rd,
  output logic             pend_valid,
  output logic [4:0]       pend_rd_addr,
  output logic             mem_err,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rf_write, w_rf_write;
  logic [4:0]        r_rf_rd_addr, w_rf_rd_addr;
  logic [XLEN-1:0]   r_rf_rd, w_rf_rd;
  logic              r_pend_valid, w_pend_valid;
  logic [4:0]        r_pend_rd_addr, w_pend_rd_addr;
  logic              r_mem_err, w_err_set;
  logic [CNT_W-1:0]  r_retire_count;
  logic              w_retire, w_capture;
  logic [4:0]        r_ld_rd;
  logic              r_ld_we;
  logic [2:0]        r_ld_funct3;
  logic [1:0]        r_ld_addr_lo;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;
  logic              w_ex_fire;
  logic              w_f3_illegal;

  assign ex_ready     = (r_state == IDLE);
  assign w_ex_fire    = ex_valid && ex_ready;
  assign w_f3_illegal = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);

  // Half select ignores addr_lo[0]: misaligned halves never reach this stage.
  assign w_byte = mem_rdata[{r_ld_addr_lo, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_ld_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rf_write     = 1'b0;
    w_rf_rd_addr   = r_rf_rd_addr;
    w_rf_rd        = r_rf_rd;
    w_pend_valid   = r_pend_valid;
    w_pend_rd_addr = r_pend_rd_addr;
    w_retire       = 1'b0;
    w_capture      = 1'b0;
    w_err_set      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_rvalid) w_err_set = 1'b1;
        if (w_ex_fire) begin
          if (ex_is_load) begin
            w_capture      = 1'b1;
            w_pend_valid   = ex_reg_write && (ex_rd_addr != 5'd0);
            w_pend_rd_addr = w_pend_valid ? ex_rd_addr : 5'd0;
            if (w_f3_illegal) w_err_set = 1'b1;
            w_state_nxt    = LOAD_WAIT;
          end else begin
            w_rf_write   = ex_reg_write && (ex_rd_addr != 5'd0);
            w_rf_rd_addr = ex_rd_addr;
            w_rf_rd      = ex_result;
            w_retire     = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          w_rf_write     = r_ld_we && (r_ld_rd != 5'd0);
          w_rf_rd_addr   = r_ld_rd;
          w_rf_rd        = w_load_data;
          w_retire       = 1'b1;
          w_pend_valid   = 1'b0;
          w_pend_rd_addr = 5'd0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rf_write     <= 1'b0;
      r_rf_rd_addr   <= 5'd0;
      r_rf_rd        <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_rd_addr <= 5'd0;
      r_mem_err      <= 1'b0;
      r_retire_count <= '0;
      r_ld_rd        <= 5'd0;
      r_ld_we        <= 1'b0;
      r_ld_funct3    <= 3'd0;
      r_ld_addr_lo   <= 2'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_rf_write     <= w_rf_write;
      r_rf_rd_addr   <= w_rf_rd_addr;
      r_rf_rd        <= w_rf_rd;
      r_pend_valid   <= w_pend_valid;
      r_pend_rd_addr <= w_pend_rd_addr;
      if (w_err_set) r_mem_err <= 1'b1;
      if (w_retire)  r_retire_count <= r_retire_count + CNT_W'(1);
      if (w_capture) begin
        r_ld_rd      <= ex_rd_addr;
        r_ld_we      <= ex_reg_write;
        r_ld_funct3  <= ex_funct3;
        r_ld_addr_lo <= ex_addr_lo;
      end
    end
  end

  assign rf_write     = r_rf_write;
  assign rf_rd_addr   = r_rf_rd_addr;
  assign rf_rd        = r_rf_rd;
  assign pend_valid   = r_pend_valid;
  assign pend_rd_addr = r_pend_rd_addr;
  assign mem_err      = r_mem_err;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver pushes expected retirements, monitor pops on each retire_count step.
module tb_writeback_stage;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid, ex_ready, ex_reg_write, ex_is_load;
  logic [4:0] ex_rd_addr;
  logic [31:0] ex_result;
  logic [2:0] ex_funct3;
  logic [1:0] ex_addr_lo;
  logic mem_rvalid;
  logic [31:0] mem_rdata;
  logic rf_write, pend_valid, mem_err;
  logic [4:0] rf_rd_addr, pend_rd_addr;
  logic [31:0] rf_rd;
  logic [CNT_W-1:0] retire_count;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg_write(ex_reg_write),
    .ex_rd_addr(ex_rd_addr), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_write(rf_write), .rf_rd_addr(rf_rd_addr), .rf_rd(rf_rd),
    .pend_valid(pend_valid), .pend_rd_addr(pend_rd_addr),
    .mem_err(mem_err), .retire_count(retire_count)
  );

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] dat;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int retired = 0;
  bit m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from the architectural rules.
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] d);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = (d >> (8 * alo)) % 256;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (d >> (16 * (alo / 2))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v[31:0];
  endfunction

  function automatic bit f3_bad(input logic [2:0] f3);
    return f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
  endfunction

  // Monitor: each retire_count step must match the oldest expected retirement.
  logic [CNT_W-1:0] prev_cnt = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_cnt = '0;
    end else if (retire_count != prev_cnt) begin
      prev_cnt = retire_count;
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 32'(retire_count), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write", 32'(rf_write), 32'(e.we));
        chk("retire_count", 32'(retire_count), 32'(e.cnt % (1 << CNT_W)));
        chk("mem_err", 32'(mem_err), 32'(e.err));
        if (e.we) begin
          chk("rf_rd_addr", 32'(rf_rd_addr), 32'(e.rd));
          chk("rf_rd", rf_rd, e.dat);
        end
      end
    end else if (rf_write) begin
      chk("write_without_retire", 32'(rf_write), 32'd0);
    end
  end

  task automatic issue_alu(input bit we, input logic [4:0] rd, input logic [31:0] res);
    exp_t e;
    ex_valid = 1; ex_is_load = 0; ex_reg_write = we; ex_rd_addr = rd;
    ex_result = res; ex_funct3 = 3'($urandom); ex_addr_lo = 2'($urandom);
    @(posedge clk); #1;
    ex_valid = 0;
    retired++;
    e.we = we && rd != 0; e.rd = rd; e.dat = res; e.cnt = retired; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic issue_load(input bit we, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] alo, input int gap, input logic [31:0] rdata);
    exp_t e;
    bit pv;
    ex_valid = 1; ex_is_load = 1; ex_reg_write = we; ex_rd_addr = rd;
    ex_result = 32'($urandom); ex_funct3 = f3; ex_addr_lo = alo;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0;
    if (f3_bad(f3)) m_err = 1;
    pv = we && rd != 0;
    chk("ld_ex_ready", 32'(ex_ready), 32'd0);
    chk("pend_valid", 32'(pend_valid), 32'(pv));
    chk("pend_rd_addr", 32'(pend_rd_addr), pv ? 32'(rd) : 32'd0);
    for (int i = 1; i < gap; i++) begin
      // Junk offered while stalled must be ignored.
      ex_valid = 1'($urandom); ex_is_load = 1'($urandom); ex_reg_write = 1;
      ex_rd_addr = 5'($urandom); ex_funct3 = 3'b111;
      @(posedge clk); #1;
      ex_valid = 0;
      chk("wait_ex_ready", 32'(ex_ready), 32'd0);
      chk("wait_pend_valid", 32'(pend_valid), 32'(pv));
    end
    retired++;
    e.we = pv; e.rd = rd; e.dat = fmt(f3, alo, rdata); e.cnt = retired; e.err = m_err;
    exp_q.push_back(e);
    mem_rvalid = 1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 0; mem_rdata = 32'($urandom);
    chk("done_ex_ready", 32'(ex_ready), 32'd1);
    chk("done_pend_valid", 32'(pend_valid), 32'd0);
    chk("done_pend_rd_addr", 32'(pend_rd_addr), 32'd0);
  endtask

  initial begin
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst_n = 0; ex_valid = 0; ex_reg_write = 0; ex_rd_addr = 0; ex_result = 0;
    ex_is_load = 0; ex_funct3 = 0; ex_addr_lo = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_rd", rf_rd, 32'd0);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_retire_count", 32'(retire_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);

    issue_alu(1, 5'd5, 32'h0000_1234);
    chk("alu_ex_ready", 32'(ex_ready), 32'd1);
    issue_load(1, 5'd7, 3'b000, 2'd2, 2, 32'h1280_3456);
    issue_load(1, 5'd9, 3'b101, 2'd2, 1, 32'h8001_F00F);
    issue_load(1, 5'd10, 3'b001, 2'd0, 3, 32'h8001_F00F);
    issue_alu(1, 5'd0, 32'hCAFE_0000);
    issue_alu(0, 5'd12, 32'h1111_2222);
    chk("err_before_bad_f3", 32'(mem_err), 32'd0);
    issue_load(1, 5'd11, 3'b111, 2'd1, 2, 32'h8001_F00F);
    chk("err_after_bad_f3", 32'(mem_err), 32'd1);

    // Reset while a load is outstanding.
    ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd_addr = 5'd3; ex_funct3 = 3'b010;
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_rf_write", 32'(rf_write), 32'd0);
    chk("midrst_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
    chk("midrst_rf_rd", rf_rd, 32'd0);
    chk("midrst_pend_valid", 32'(pend_valid), 32'd0);
    chk("midrst_pend_rd_addr", 32'(pend_rd_addr), 32'd0);
    chk("midrst_mem_err", 32'(mem_err), 32'd0);
    chk("midrst_retire_count", 32'(retire_count), 32'd0);
    retired = 0; m_err = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 0;
    m_err = 1;
    chk("idle_rvalid_no_write", 32'(rf_write), 32'd0);
    chk("idle_rvalid_err", 32'(mem_err), 32'd1);
    chk("idle_rvalid_count", 32'(retire_count), 32'd0);

    // Random traffic; long enough for the 8-bit counter to wrap twice.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 2) == 0)
        issue_load(1'($urandom_range(0, 7) != 0), 5'($urandom),
                   ($urandom_range(0, 9) == 0) ? 3'b110 : legal_f3[$urandom_range(0, 4)],
                   2'($urandom), $urandom_range(1, 3), 32'($urandom));
      else
        issue_alu(1'($urandom_range(0, 3) != 0), 5'($urandom), 32'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_count", 32'(retire_count), 32'(retired % (1 << CNT_W)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
